// File: rtl/vtg_pkg.sv
// ---------------------------------------------------------------------------
// vtg_pkg
//   Shared definitions for the video timing generator:
//     - vtg_phase_t : phase of one raster axis (active, front porch, sync,
//                     back porch)
//     - DEF_*       : VESA 800x600@60 timing (40.000 MHz pixel clock)
//     - POS_W       : width of the hPos / vPos coordinate outputs
//     - FC_W        : width of the optional frame counter
//     - axis_total  : clocks (or lines) in one full period of an axis
//     - axis_legal  : elaboration-time legality test for one axis
// ---------------------------------------------------------------------------
package vtg_pkg;

    localparam int POS_W      = 10;
    localparam int FC_W       = 8;
    localparam int MAX_ACTIVE = 1024;

    // VESA 800x600@60, 40.000 MHz pixel clock
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FRONT  = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BACK   = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FRONT  = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BACK   = 23;

    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SYN = 2'd2,
        PH_BP  = 2'd3
    } vtg_phase_t;

    function automatic int axis_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

    function automatic bit axis_legal(input int active, input int front,
                                      input int sync, input int back);
        return (active >= 1) && (active <= MAX_ACTIVE) &&
               (front >= 1) && (sync >= 1) && (back >= 1);
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// ---------------------------------------------------------------------------
// vtg_axis_counter
//   One raster axis: a position counter 0..TOTAL-1 plus a phase FSM
//   (ACT -> FP -> SYN -> BP -> ACT) that tracks which region the counter is
//   in. Both only move when i_adv is high. The horizontal axis advances every
//   clock; the vertical axis advances on the horizontal wrap flag, so its
//   count and phase only change on line boundaries.
//
// Ports
//   i_clk    in   1        clock
//   i_reset  in   1        synchronous active-high reset (count 0, phase ACT)
//   i_adv    in   1        advance enable
//   o_count  out  CNT_W    current position
//   o_phase  out  phase    current phase (FSM state, also useful as debug)
//   o_wrap   out  1        high when this clock moves the count TOTAL-1 -> 0
// ---------------------------------------------------------------------------
module vtg_axis_counter
    import vtg_pkg::*;
#(
    parameter int  ACTIVE = DEF_H_ACTIVE,
    parameter int  FRONT  = DEF_H_FRONT,
    parameter int  SYNC   = DEF_H_SYNC,
    parameter int  BACK   = DEF_H_BACK,
    localparam int TOTAL  = axis_total(ACTIVE, FRONT, SYNC, BACK),
    localparam int CNT_W  = $clog2(TOTAL)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_adv,
    output logic [CNT_W-1:0] o_count,
    output vtg_phase_t       o_phase,
    output logic             o_wrap
);

    // Last position of each phase; the phase steps on the advance that
    // leaves that position.
    localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP  = CNT_W'(ACTIVE + FRONT - 1);
    localparam logic [CNT_W-1:0] LAST_SYN = CNT_W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] r_count;
    vtg_phase_t       r_phase;
    vtg_phase_t       w_phase_next;
    logic             w_wrap;

    assign w_wrap = i_adv && (r_count == LAST_CNT);

    // Phase FSM: next-state logic
    always_comb begin
        w_phase_next = r_phase;
        if (i_adv) begin
            case (r_phase)
                PH_ACT:  if (r_count == LAST_ACT) w_phase_next = PH_FP;
                PH_FP:   if (r_count == LAST_FP)  w_phase_next = PH_SYN;
                PH_SYN:  if (r_count == LAST_SYN) w_phase_next = PH_BP;
                PH_BP:   if (r_count == LAST_CNT) w_phase_next = PH_ACT;
                default: w_phase_next = PH_ACT;
            endcase
        end
    end

    // Phase FSM state register and position counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase <= PH_ACT;
            r_count <= '0;
        end else begin
            r_phase <= w_phase_next;
            if (i_adv) begin
                r_count <= w_wrap ? '0 : r_count + CNT_W'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_phase = r_phase;
    assign o_wrap  = w_wrap;

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Raster timing source for the 40 MHz video path. Two vtg_axis_counter
//   instances (horizontal, vertical) hold the raster position; every output
//   is a registered decode of that position, so all outputs share one clock
//   of latency and stay mutually aligned.
//
// Ports
//   clk40        in   1      pixel clock, the only clock
//   reset        in   1      synchronous active-high reset
//   hsync        out  1      horizontal sync, asserted level = H_SYNC_POL
//   vsync        out  1      vertical sync, asserted level = V_SYNC_POL
//   videoActive  out  1      both axes in their active phase
//   hPos         out  10     pixel column while videoActive, else 0
//   vPos         out  10     pixel row while videoActive, else 0
//   lineStart    out  1      pulse on the first clock of every line
//   frameStart   out  1      pulse on the first clock of every frame
//   frameCount   out  8      frames completed (only with VTG_FRAME_CNT_EN)
//
// Configuration
//   VTG_FRAME_CNT_EN  when defined, adds the frameCount port and counter.
//                     It does not count the first frame after reset and
//                     wraps 255 -> 0.
// ---------------------------------------------------------------------------
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1
) (
    input  logic             clk40,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             videoActive,
    output logic [POS_W-1:0] hPos,
    output logic [POS_W-1:0] vPos,
    output logic             lineStart,
`ifdef VTG_FRAME_CNT_EN
    output logic             frameStart,
    output logic [FC_W-1:0]  frameCount
`else
    output logic             frameStart
`endif
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int H_CW    = $clog2(H_TOTAL);
    localparam int V_CW    = $clog2(V_TOTAL);

    // Refuse to build with zero-length porch/sync or an active region that
    // does not fit the 10-bit coordinate outputs.
    if (!axis_legal(H_ACTIVE, H_FRONT, H_SYNC, H_BACK)) begin : g_bad_h
        $error("video_timing_gen: illegal horizontal timing parameters");
    end
    if (!axis_legal(V_ACTIVE, V_FRONT, V_SYNC, V_BACK)) begin : g_bad_v
        $error("video_timing_gen: illegal vertical timing parameters");
    end

    logic [H_CW-1:0]  w_hcount;
    logic [V_CW-1:0]  w_vcount;
    vtg_phase_t       w_hphase;
    vtg_phase_t       w_vphase;
    logic             w_h_wrap;
    logic             w_v_wrap;

    vtg_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .i_clk   (clk40),
        .i_reset (reset),
        .i_adv   (1'b1),
        .o_count (w_hcount),
        .o_phase (w_hphase),
        .o_wrap  (w_h_wrap)
    );

    // Stepping only on the horizontal wrap keeps vertical phase changes on
    // line boundaries.
    vtg_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .i_clk   (clk40),
        .i_reset (reset),
        .i_adv   (w_h_wrap),
        .o_count (w_vcount),
        .o_phase (w_vphase),
        .o_wrap  (w_v_wrap)
    );

    // Decode of the current raster position; registered below.
    logic             w_active;
    logic             w_line_start;
    logic             w_frame_start;
    logic             w_hsync;
    logic             w_vsync;
    logic [POS_W-1:0] w_hpos;
    logic [POS_W-1:0] w_vpos;

    assign w_active      = (w_hphase == PH_ACT) && (w_vphase == PH_ACT);
    assign w_line_start  = (w_hcount == '0);
    assign w_frame_start = w_line_start && (w_vcount == '0);
    assign w_hsync       = (w_hphase == PH_SYN) ? H_SYNC_POL : ~H_SYNC_POL;
    assign w_vsync       = (w_vphase == PH_SYN) ? V_SYNC_POL : ~V_SYNC_POL;
    // While active the counts are below 1024, so the resize never drops bits.
    assign w_hpos        = w_active ? POS_W'(w_hcount) : '0;
    assign w_vpos        = w_active ? POS_W'(w_vcount) : '0;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_active;
    logic [POS_W-1:0] r_hpos;
    logic [POS_W-1:0] r_vpos;
    logic             r_line_start;
    logic             r_frame_start;

    always_ff @(posedge clk40) begin
        if (reset) begin
            r_hsync       <= ~H_SYNC_POL;
            r_vsync       <= ~V_SYNC_POL;
            r_active      <= 1'b0;
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_active      <= w_active;
            r_hpos        <= w_hpos;
            r_vpos        <= w_vpos;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign videoActive = r_active;
    assign hPos        = r_hpos;
    assign vPos        = r_vpos;
    assign lineStart   = r_line_start;
    assign frameStart  = r_frame_start;

`ifdef VTG_FRAME_CNT_EN
    // The count updates on the same clock edge that raises frameStart, so it
    // is aligned with the other outputs. r_frame_seen skips the first frame
    // after reset, which is a start rather than a completed frame.
    logic [FC_W-1:0] r_frame_count;
    logic            r_frame_seen;
    logic            w_frame_wrap_unused;

    assign w_frame_wrap_unused = w_v_wrap;

    always_ff @(posedge clk40) begin
        if (reset) begin
            r_frame_count <= '0;
            r_frame_seen  <= 1'b0;
        end else if (w_frame_start) begin
            r_frame_seen <= 1'b1;
            if (r_frame_seen) begin
                r_frame_count <= r_frame_count + FC_W'(1);
            end
        end
    end

    assign frameCount = r_frame_count;
`else
    // The vertical wrap flag has no consumer without the frame counter.
    logic w_frame_wrap_unused;
    assign w_frame_wrap_unused = w_v_wrap;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//   Two instances on one clock:
//     dut_d : default 800x600@60 timing, active-high syncs
//     dut_s : H 4/1/2/1, V 3/1/1/1, active-low syncs (8x6 clock grid)
//   A raster model per instance pushes the expected output word into an
//   expected queue on every rising edge; a monitor pops and compares on the
//   falling edge. Directed checks cover reset release, mid-frame reset and
//   line/frame measurements.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int DH_A = 800, DH_F = 40, DH_S = 128, DH_B = 88;
    localparam int DV_A = 600, DV_F = 1,  DV_S = 4,   DV_B = 23;
    localparam int SH_A = 4,   SH_F = 1,  SH_S = 2,   SH_B = 1;
    localparam int SV_A = 3,   SV_F = 1,  SV_S = 1,   SV_B = 1;
    localparam int D_HT = 1056, D_VT = 628;
    localparam int S_HT = 8,    S_VT = 6;
`ifdef VTG_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk40 = 1'b0;
    always #12 clk40 = ~clk40;

    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    bit   sb_on = 1'b0;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT wiring ----------------
    logic       d_hsync, d_vsync, d_va, d_ls, d_fs;
    logic [9:0] d_hpos, d_vpos;
    logic [7:0] d_fc;
    logic       s_hsync, s_vsync, s_va, s_ls, s_fs;
    logic [9:0] s_hpos, s_vpos;
    logic [7:0] s_fc;

    video_timing_gen dut_d (
        .clk40       (clk40),
        .reset       (rst_d),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .videoActive (d_va),
        .hPos        (d_hpos),
        .vPos        (d_vpos),
        .lineStart   (d_ls),
`ifdef VTG_FRAME_CNT_EN
        .frameStart  (d_fs),
        .frameCount  (d_fc)
`else
        .frameStart  (d_fs)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE (SH_A), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
        .V_ACTIVE (SV_A), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B),
        .H_SYNC_POL (1'b0), .V_SYNC_POL (1'b0)
    ) dut_s (
        .clk40       (clk40),
        .reset       (rst_s),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .videoActive (s_va),
        .hPos        (s_hpos),
        .vPos        (s_vpos),
        .lineStart   (s_ls),
`ifdef VTG_FRAME_CNT_EN
        .frameStart  (s_fs),
        .frameCount  (s_fc)
`else
        .frameStart  (s_fs)
`endif
    );

`ifndef VTG_FRAME_CNT_EN
    assign d_fc = 8'd0;
    assign s_fc = 8'd0;
`endif

    // Output word: {hsync, vsync, active, hPos, vPos, lineStart, frameStart, frameCount}
    logic [32:0] d_act, s_act;
    assign d_act = {d_hsync, d_vsync, d_va, d_hpos, d_vpos, d_ls, d_fs, d_fc};
    assign s_act = {s_hsync, s_vsync, s_va, s_hpos, s_vpos, s_ls, s_fs, s_fc};

    // ---------------- check helpers ----------------
    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [32:0] exp_vec(input int h, input int v,
                                            input int ha, input int hf, input int hs,
                                            input int va, input int vf, input int vs,
                                            input bit hpol, input bit vpol, input int fc);
        logic       act, hsy, vsy;
        logic [9:0] hp, vp;
        act = (h < ha) && (v < va);
        hsy = (h >= ha + hf && h < ha + hf + hs) ? hpol : ~hpol;
        vsy = (v >= va + vf && v < va + vf + vs) ? vpol : ~vpol;
        hp  = act ? 10'(h) : 10'd0;
        vp  = act ? 10'(v) : 10'd0;
        return {hsy, vsy, act, hp, vp, (h == 0), (h == 0 && v == 0), 8'(fc)};
    endfunction

    function automatic logic [32:0] rst_vec(input bit hpol, input bit vpol);
        return {~hpol, ~vpol, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 8'd0};
    endfunction

    logic [32:0] d_exp_q[$];
    logic [32:0] s_exp_q[$];

    // Models: run on the rising edge, predicting the outputs after that edge.
    int m_dh, m_dv, m_dfc; bit m_dst;
    int m_sh, m_sv, m_sfc; bit m_sst;

    initial forever begin
        @(posedge clk40);
        if (sb_on) begin
            if (rst_d) begin
                d_exp_q.push_back(rst_vec(1'b1, 1'b1));
                m_dh = 0; m_dv = 0; m_dfc = 0; m_dst = 0;
            end else begin
                if (m_dh == 0 && m_dv == 0) begin
                    if (m_dst) m_dfc = (m_dfc + 1) % 256;
                    m_dst = 1;
                end
                d_exp_q.push_back(exp_vec(m_dh, m_dv, DH_A, DH_F, DH_S, DV_A, DV_F, DV_S,
                                          1'b1, 1'b1, FC_EN ? m_dfc : 0));
                m_dh++;
                if (m_dh == D_HT) begin
                    m_dh = 0;
                    m_dv = (m_dv + 1 == D_VT) ? 0 : m_dv + 1;
                end
            end
            if (rst_s) begin
                s_exp_q.push_back(rst_vec(1'b0, 1'b0));
                m_sh = 0; m_sv = 0; m_sfc = 0; m_sst = 0;
            end else begin
                if (m_sh == 0 && m_sv == 0) begin
                    if (m_sst) m_sfc = (m_sfc + 1) % 256;
                    m_sst = 1;
                end
                s_exp_q.push_back(exp_vec(m_sh, m_sv, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S,
                                          1'b0, 1'b0, FC_EN ? m_sfc : 0));
                m_sh++;
                if (m_sh == S_HT) begin
                    m_sh = 0;
                    m_sv = (m_sv + 1 == S_VT) ? 0 : m_sv + 1;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [32:0] e_d, e_s;
    initial forever begin
        @(negedge clk40);
        if (d_exp_q.size() > 0) begin
            e_d = d_exp_q.pop_front();
            check_vec("d_sb", d_act, e_d);
        end
        if (s_exp_q.size() > 0) begin
            e_s = s_exp_q.pop_front();
            check_vec("s_sb", s_act, e_s);
        end
    end

    // ---------------- line measurements (default timing) ----------------
    int d_since_ls, d_hs_cnt, d_hs_first;
    bit d_seen_ls, d_prev_va;
    int d_prev_hpos;
    initial forever begin
        @(negedge clk40);
        if (rst_d || !sb_on) begin
            d_seen_ls = 0;
            d_prev_va = 0;
        end else begin
            if (d_ls) begin
                if (d_seen_ls) begin
                    check_int("d_line_period", d_since_ls, 1056);
                    check_int("d_hsync_width", d_hs_cnt, 128);
                    check_int("d_hsync_start", d_hs_first, 840);
                end
                d_seen_ls  = 1;
                d_since_ls = 0;
                d_hs_cnt   = 0;
                d_hs_first = -1;
            end
            if (d_seen_ls && d_hsync) begin
                if (d_hs_first < 0) d_hs_first = d_since_ls;
                d_hs_cnt++;
            end
            d_since_ls++;
            if (!d_va && d_prev_va) check_int("d_hpos_last", d_prev_hpos, 799);
            d_prev_va   = d_va;
            d_prev_hpos = int'(d_hpos);
        end
    end

    // ---------------- frame measurements (small timing) ----------------
    int s_ls_in_frame, s_vpos_max, s_vs_lines;
    bit s_seen_fs;
    initial forever begin
        @(negedge clk40);
        if (rst_s || !sb_on) begin
            s_seen_fs = 0;
        end else begin
            if (s_fs) begin
                if (s_seen_fs) begin
                    check_int("s_lines_per_frame", s_ls_in_frame, 6);
                    check_int("s_vpos_max", s_vpos_max, 2);
                    check_int("s_vsync_lines", s_vs_lines, 1);
                end
                s_seen_fs     = 1;
                s_ls_in_frame = 0;
                s_vpos_max    = 0;
                s_vs_lines    = 0;
            end
            if (s_seen_fs && s_ls) begin
                s_ls_in_frame++;
                if (s_vsync == 1'b0) s_vs_lines++;
            end
            if (s_va && int'(s_vpos) > s_vpos_max) s_vpos_max = int'(s_vpos);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_default();
        int n;
        n = 0;
        while (!(d_va && d_hpos == 10'd500 && d_vpos == 10'd1) && n < 3000) begin
            @(posedge clk40); #2;
            n++;
        end
        check_int("d_wait_500_1", (n < 3000) ? 1 : 0, 1);
        rst_d = 1'b1;
        @(posedge clk40); #2;
        rst_d = 1'b0;
        check_int("d_midrst_va", d_va, 0);
        check_int("d_midrst_hpos", d_hpos, 0);
        check_int("d_midrst_vpos", d_vpos, 0);
        check_int("d_midrst_ls", d_ls, 0);
        check_int("d_midrst_hsync", d_hsync, 0);
        @(posedge clk40); #2;
        check_int("d_restart_va", d_va, 1);
        check_int("d_restart_ls", d_ls, 1);
        check_int("d_restart_fs", d_fs, 1);
        check_int("d_restart_hpos", d_hpos, 0);
        repeat (2200) @(posedge clk40);
        #2;
        check_int("d_line2_vpos", d_vpos, 2);
    endtask

    task automatic drive_small();
        int n;
        repeat (260 * 48) @(posedge clk40);
        #2;
        n = 0;
        while (!(s_va && s_hpos == 10'd2 && s_vpos == 10'd1) && n < 100) begin
            @(posedge clk40); #2;
            n++;
        end
        check_int("s_wait_2_1", (n < 100) ? 1 : 0, 1);
        rst_s = 1'b1;
        @(posedge clk40); #2;
        rst_s = 1'b0;
        check_int("s_midrst_va", s_va, 0);
        check_int("s_midrst_hsync", s_hsync, 1);
        check_int("s_midrst_vsync", s_vsync, 1);
`ifdef VTG_FRAME_CNT_EN
        check_int("s_midrst_fc", s_fc, 0);
`endif
        @(posedge clk40); #2;
        check_int("s_restart_fs", s_fs, 1);
        check_int("s_restart_va", s_va, 1);
        repeat (3 * 48) @(posedge clk40);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_d = 1'b1;
        rst_s = 1'b1;
        sb_on = 1'b1;
        repeat (2) @(posedge clk40);
        #2;
        check_int("d_reset_va", d_va, 0);
        check_int("d_reset_hsync", d_hsync, 0);
        check_int("s_reset_hsync", s_hsync, 1);
        check_int("s_reset_fs", s_fs, 0);
        rst_d = 1'b0;
        rst_s = 1'b0;
        @(posedge clk40); #2;
        check_int("d_rel_va", d_va, 1);
        check_int("d_rel_hpos", d_hpos, 0);
        check_int("d_rel_vpos", d_vpos, 0);
        check_int("d_rel_ls", d_ls, 1);
        check_int("d_rel_fs", d_fs, 1);
        check_int("d_rel_hsync", d_hsync, 0);
        check_int("d_rel_vsync", d_vsync, 0);
        check_int("s_rel_va", s_va, 1);
        check_int("s_rel_fs", s_fs, 1);
        check_int("s_rel_hsync", s_hsync, 1);
        fork
            drive_default();
            drive_small();
        join
        repeat (4) @(posedge clk40);
        #2;
        sb_on = 1'b0;
        repeat (2) @(posedge clk40);
        #2;
        check_int("d_q_drained", d_exp_q.size(), 0);
        check_int("s_q_drained", s_exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
